ysyx_24110006_writeback: RTL

- Writeback unit that drives the register file's single write port (wen/waddr/wdata).
- Arbitrates completed results from EXU and LSU with valid/ready handshakes, then registers one write per cycle toward the register file.
- Holds a pending-write scoreboard, one busy bit per architectural register.
- The scoreboard gates issue of new writers and reports read-after-write hazards for the decode stage's two read addresses.

---
 rtl/ysyx_24110006_writeback_if.sv | 42 ++++
 rtl/ysyx_24110006_writeback.sv | 82 ++++++++
 2 files changed

// File: rtl/ysyx_24110006_writeback_if.sv
// Bus bundle between decode/EXU/LSU and the writeback unit.
// The slave modport is the writeback unit; the master modport drives it.
interface ysyx_24110006_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_issue_valid;
  logic [ADDR_WIDTH-1:0] i_issue_rd;
  logic                  o_issue_ready;
  logic [ADDR_WIDTH-1:0] i_raddr1;
  logic [ADDR_WIDTH-1:0] i_raddr2;
  logic                  o_busy1;
  logic                  o_busy2;
  logic                  i_exu_valid;
  logic [ADDR_WIDTH-1:0] i_exu_rd;
  logic [DATA_WIDTH-1:0] i_exu_data;
  logic                  o_exu_ready;
  logic                  i_lsu_valid;
  logic [ADDR_WIDTH-1:0] i_lsu_rd;
  logic [DATA_WIDTH-1:0] i_lsu_data;
  logic                  o_lsu_ready;
  logic                  o_wen;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic [31:0]           o_commit_cnt;

  modport slave (
    input  i_issue_valid, i_issue_rd, i_raddr1, i_raddr2,
    input  i_exu_valid, i_exu_rd, i_exu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_issue_ready, o_busy1, o_busy2, o_exu_ready, o_lsu_ready,
    output o_wen, o_waddr, o_wdata, o_commit_cnt
  );

  modport master (
    output i_issue_valid, i_issue_rd, i_raddr1, i_raddr2,
    output i_exu_valid, i_exu_rd, i_exu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  o_issue_ready, o_busy1, o_busy2, o_exu_ready, o_lsu_ready,
    input  o_wen, o_waddr, o_wdata, o_commit_cnt
  );
endinterface

// File: rtl/ysyx_24110006_writeback.sv
// Writeback unit: round-robin EXU/LSU arbitration into a registered register
// file write port, plus a per-register pending-write scoreboard.
module ysyx_24110006_writeback #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                      i_clock,
  input logic                      i_reset,
  ysyx_24110006_writeback_if.slave bus
);
  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W    = 32;

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  prefer_lsu;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [CNT_W-1:0]      commit_cnt;

  logic                  grant_lsu_c;
  logic                  grant_exu_c;
  logic                  exu_ready_c;
  logic                  lsu_ready_c;
  logic                  issue_ready_c;
  logic                  issue_set_c;
  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] sel_rd_c;
  logic [DATA_WIDTH-1:0] sel_data_c;

  // Grant depends only on valids and the pointer, never on data fields
  always_comb begin
    grant_lsu_c   = bus.i_lsu_valid && (!bus.i_exu_valid || prefer_lsu);
    grant_exu_c   = bus.i_exu_valid && !grant_lsu_c;
    exu_ready_c   = grant_exu_c && !i_reset;
    lsu_ready_c   = grant_lsu_c && !i_reset;
    accept_c      = exu_ready_c || lsu_ready_c;
    sel_rd_c      = grant_exu_c ? bus.i_exu_rd : bus.i_lsu_rd;
    sel_data_c    = grant_exu_c ? bus.i_exu_data : bus.i_lsu_data;
    issue_ready_c = !i_reset && ((bus.i_issue_rd == '0) || !busy[bus.i_issue_rd]);
    issue_set_c   = bus.i_issue_valid && issue_ready_c && (bus.i_issue_rd != '0);
  end

  // Clear on commit, then set on issue so a same-edge set wins
  always_comb begin
    busy_next = busy;
    if (wen) busy_next[waddr] = 1'b0;
    if (issue_set_c) busy_next[bus.i_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy       <= '0;
      prefer_lsu <= 1'b1;
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      commit_cnt <= '0;
    end else begin
      busy <= busy_next;
      wen  <= accept_c && (sel_rd_c != '0);
      if (accept_c) begin
        prefer_lsu <= grant_exu_c;
        waddr      <= sel_rd_c;
        wdata      <= sel_data_c;
      end
      if (wen) commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end

  assign bus.o_issue_ready = issue_ready_c;
  assign bus.o_busy1       = busy[bus.i_raddr1];
  assign bus.o_busy2       = busy[bus.i_raddr2];
  assign bus.o_exu_ready   = exu_ready_c;
  assign bus.o_lsu_ready   = lsu_ready_c;
  assign bus.o_wen         = wen;
  assign bus.o_waddr       = waddr;
  assign bus.o_wdata       = wdata;
  assign bus.o_commit_cnt  = commit_cnt;
endmodule
